// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared types and constants for the tone sequencer
package tone_pkg;
  localparam int MS_PER_S    = 1000;
  localparam int NOTE_FREQ_W = 10;
  localparam int NOTE_DUR_W  = 12;

  typedef struct packed {
    logic [NOTE_FREQ_W-1:0] freq;
    logic [NOTE_DUR_W-1:0]  dur_ms;
  } note_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;
endpackage

// File: rtl/tone_nco.sv
// rtl/tone_nco.sv - phase accumulator producing a square wave at freq Hz
module tone_nco #(
  parameter int FREQ_W = 10,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [FREQ_W-1:0] freq,
  input  logic [ACC_W-1:0]  half,
  output logic              sound
);
  logic [ACC_W-1:0] acc;
  logic             phase_hi;

  // half = one half-period expressed in freq-units, so each overflow is one toggle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      phase_hi <= 1'b0;
    end else if (clr) begin
      acc      <= '0;
      phase_hi <= 1'b0;
    end else if (en) begin
      if (freq == '0) begin
        acc <= '0;
      end else if (acc >= half) begin
        phase_hi <= ~phase_hi;
        acc      <= acc + ACC_W'(freq) - half;
      end else begin
        acc <= acc + ACC_W'(freq);
      end
    end
  end

  assign sound = phase_hi & en;
endmodule

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - queued timed square-wave note player with flush
// Define TONE_SEQ_GAP_EN to insert GAP_MS ms of silence after every non-empty note.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int FREQ_W = 10,
  parameter int DUR_W  = 12,
  parameter int DEPTH  = 4,
  parameter int ACC_W  = 32,
  parameter int GAP_MS = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                ticks_per_milli,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FREQ_W-1:0]          in_freq,
  input  logic [DUR_W-1:0]           in_dur_ms,
  input  logic                       flush,
  output logic                       sound,
  output logic                       busy,
  output logic                       note_done,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [FREQ_W+DUR_W-1:0] mem [DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  state_t                  state, state_n;
  logic                    push, pop, done_n;
  logic [FREQ_W-1:0]       cur_freq;
  logic [DUR_W-1:0]        cur_dur, ms_cnt;
  logic [15:0]             tick_cnt, tpm_m1;
  logic                    tick_wrap, ms_end;
  logic [ACC_W-1:0]        half;

  assign tpm_m1    = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
  assign half      = ((ACC_W'(tpm_m1) + ACC_W'(1)) * ACC_W'(MS_PER_S)) >> 1;
  // >= so a mid-note drop of ticks_per_milli still closes the current ms
  assign tick_wrap = tick_cnt >= tpm_m1;
  assign ms_end    = tick_wrap && (ms_cnt <= DUR_W'(1));

  assign in_ready = (level != LW'(DEPTH)) && !flush;
  assign push     = in_valid && in_ready;
  assign busy     = (state != S_IDLE) || (level != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_freq, in_dur_ms};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      note_done <= 1'b0;
      cur_freq  <= '0;
      cur_dur   <= '0;
    end else begin
      state     <= state_n;
      note_done <= done_n;
      if (pop) {cur_freq, cur_dur} <= mem[rd_ptr];
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (level != '0) begin
          pop     = 1'b1;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cur_dur == '0) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          state_n = S_PLAY;
        end
      end
      S_PLAY: begin
        if (ms_end) begin
          done_n  = 1'b1;
`ifdef TONE_SEQ_GAP_EN
          state_n = S_GAP;
`else
          state_n = S_IDLE;
`endif
        end
      end
      default: begin
        if (ms_end) state_n = S_IDLE;
      end
    endcase
    if (flush) begin
      state_n = S_IDLE;
      pop     = 1'b0;
      done_n  = 1'b0;
    end
  end

  // the gap length is preloaded at note end; it is simply ignored when no gap follows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
    end else if (flush) begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
    end else if (state == S_LOAD) begin
      tick_cnt <= '0;
      ms_cnt   <= cur_dur;
    end else if (state == S_PLAY || state == S_GAP) begin
      if (!tick_wrap) begin
        tick_cnt <= tick_cnt + 16'd1;
      end else begin
        tick_cnt <= '0;
        if (ms_end && state == S_PLAY) ms_cnt <= DUR_W'(GAP_MS);
        else if (ms_cnt != '0)         ms_cnt <= ms_cnt - DUR_W'(1);
      end
    end
  end

  tone_nco #(
    .FREQ_W(FREQ_W),
    .ACC_W (ACC_W)
  ) u_nco (
    .clk  (clk),
    .rst  (rst),
    .en   (state == S_PLAY),
    .clr  (state == S_LOAD),
    .freq (cur_freq),
    .half (half),
    .sound(sound)
  );
endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - self-checking bench for tone_sequencer
module tb_tone_sequencer;
  localparam int FREQ_W = 10;
  localparam int DUR_W  = 12;
  localparam int DEPTH  = 4;
  localparam int ACC_W  = 32;
  localparam int GAP_MS = 2;
`ifdef TONE_SEQ_GAP_EN
  localparam int GAP_ON = 1;
`else
  localparam int GAP_ON = 0;
`endif

  logic              clk, rst, in_valid, in_ready, flush, sound, busy, note_done;
  logic [15:0]       tpm;
  logic [FREQ_W-1:0] in_freq;
  logic [DUR_W-1:0]  in_dur_ms;
  logic [2:0]        level;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int done_q[$];

  typedef struct {
    int f;
    int d;
    int t;
    int done;
    int hi;
  } vec_t;
  vec_t vecs[7];

  tone_sequencer #(
    .FREQ_W(FREQ_W), .DUR_W(DUR_W), .DEPTH(DEPTH), .ACC_W(ACC_W), .GAP_MS(GAP_MS)
  ) dut (
    .clk(clk), .rst(rst), .ticks_per_milli(tpm), .in_valid(in_valid), .in_ready(in_ready),
    .in_freq(in_freq), .in_dur_ms(in_dur_ms), .flush(flush), .sound(sound), .busy(busy),
    .note_done(note_done), .level(level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (note_done === 1'b1) done_q.push_back(cyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int teff, lim, hi, dcnt, dcyc, bdone;
    teff = (v.t == 0) ? 1 : v.t;
    lim  = 3 + v.d * teff + 3 + GAP_ON * GAP_MS * teff;
    tpm  = 16'(v.t);
    in_valid = 1; in_freq = FREQ_W'(v.f); in_dur_ms = DUR_W'(v.d);
    step();
    in_valid = 0;
    hi = 0; dcnt = 0; dcyc = -1; bdone = -1;
    for (int c = 1; c <= lim; c++) begin
      if (sound) hi++;
      if (note_done) begin
        dcnt++;
        if (dcyc < 0) begin
          dcyc  = c;
          bdone = int'(busy);
        end
      end
      step();
    end
    wait_idle();
    check($sformatf("vec%0d_done_cycle", idx), dcyc, v.done);
    check($sformatf("vec%0d_done_count", idx), dcnt, 1);
    check($sformatf("vec%0d_high_cycles", idx), hi, v.hi);
    check($sformatf("vec%0d_busy_at_done", idx), bdone, (GAP_ON != 0 && v.d > 0) ? 1 : 0);
  endtask

  // expected sound for every PLAY cycle, from the accumulator rules in plain arithmetic
  task automatic run_random(input int idx);
    int f, d, t, teff, half, acc, n;
    bit s;
    bit q[$];
    f = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 1023));
    d = int'($urandom_range(0, 3));
    t = int'($urandom_range(0, 4));
    teff = (t == 0) ? 1 : t;
    half = teff * 1000 / 2;
    n = d * teff;
    acc = 0; s = 0;
    for (int k = 0; k < n; k++) begin
      q.push_back((f != 0) && s);
      if (f != 0) begin
        if (acc >= half) begin
          s = !s;
          acc = acc + f - half;
        end else begin
          acc = acc + f;
        end
      end
    end
    tpm = 16'(t);
    in_valid = 1; in_freq = FREQ_W'(f); in_dur_ms = DUR_W'(d);
    step();
    in_valid = 0;
    for (int c = 1; c <= 3 + n; c++) begin
      check($sformatf("rnd%0d_sound_c%0d", idx, c), sound, (c >= 3 && c < 3 + n) ? q[c-3] : 1'b0);
      check($sformatf("rnd%0d_done_c%0d", idx, c), note_done, (c == 3 + n) ? 1 : 0);
      step();
    end
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    clk = 0; rst = 1; tpm = 16'd4; in_valid = 0; in_freq = '0; in_dur_ms = '0; flush = 0;
    vecs[0] = '{f: 500,  d: 3, t: 4, done: 15, hi: 4};
    vecs[1] = '{f: 0,    d: 2, t: 4, done: 11, hi: 0};
    vecs[2] = '{f: 440,  d: 0, t: 4, done: 3,  hi: 0};
    vecs[3] = '{f: 1000, d: 4, t: 1, done: 7,  hi: 1};
    vecs[4] = '{f: 1000, d: 4, t: 0, done: 7,  hi: 1};
    vecs[5] = '{f: 250,  d: 2, t: 4, done: 11, hi: 0};
    vecs[6] = '{f: 900,  d: 3, t: 1, done: 6,  hi: 1};
    repeat (2) step();
    rst = 0;
    step();

    check("rst_sound", sound, 0);
    check("rst_note_done", note_done, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
    for (int i = 0; i < 20; i++) run_random(i);

    // five notes against a four-deep queue behind a long note
    tpm = 16'd4;
    done_q.delete();
    in_valid = 1; in_freq = '0; in_dur_ms = DUR_W'(5);
    step();
    in_valid = 0;
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill_ready%0d", i), in_ready, 1);
      in_valid = 1; in_freq = FREQ_W'(100 * (i + 1)); in_dur_ms = DUR_W'(i + 1);
      step();
    end
    in_valid = 0;
    check("full_level", level, 4);
    check("full_in_ready", in_ready, 0);
    in_valid = 1; in_freq = FREQ_W'(77); in_dur_ms = DUR_W'(5);
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    check("ready_rise_timeout", in_ready, 1);
    check("ready_rise_after_first_pop", done_q.size(), 1);
    step();
    in_valid = 0;
    n = 0;
    while (done_q.size() < 6 && n < 400) begin
      step();
      n++;
    end
    check("five_notes_done_count", done_q.size(), 6);
    for (int i = 0; i < 5; i++)
      check($sformatf("order_gap%0d", i), done_q[i+1] - done_q[i], 4 * (i + 1) + 2 + 8 * GAP_ON);
    wait_idle();

    // flush during the second of three queued notes
    tpm = 16'd1;
    done_q.delete();
    in_valid = 1; in_freq = FREQ_W'(600); in_dur_ms = DUR_W'(4);
    repeat (3) step();
    in_valid = 0;
    n = 0;
    while (!note_done && n < 100) begin
      step();
      n++;
    end
    check("flush_first_done_seen", note_done, 1);
    repeat (4 + 2 * GAP_ON) step();
    check("flush_pre_sound", sound, 1);
    flush = 1; in_valid = 1;
    #1;
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 0; in_valid = 0;
    check("flush_sound", sound, 0);
    check("flush_level", level, 0);
    check("flush_busy", busy, 0);
    check("flush_note_done", note_done, 0);
    repeat (20) step();
    check("flush_done_total", done_q.size(), 1);

    // asynchronous reset in the middle of a note
    in_valid = 1; in_freq = FREQ_W'(700); in_dur_ms = DUR_W'(10);
    step();
    in_freq = FREQ_W'(300); in_dur_ms = DUR_W'(2);
    step();
    in_valid = 0;
    repeat (3) step();
    check("arst_pre_level", level, 1);
    done_q.delete();
    rst = 1;
    #1;
    check("arst_sound", sound, 0);
    check("arst_level", level, 0);
    check("arst_busy", busy, 0);
    check("arst_note_done", note_done, 0);
    step();
    rst = 0;
    repeat (10) step();
    check("arst_no_done", done_q.size(), 0);
    check("arst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
